// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // An access is rejected when it is not word aligned or its word index lies beyond the RAM.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data bus: the pipeline (master) issues requests, the responder (slave) acks them.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_i;
  logic              we_i;
  logic [WORD_W-1:0] addr_i;
  logic [WORD_W-1:0] wdata_i;
  logic              ack_o;
  logic [WORD_W-1:0] rdata_o;
  logic              err_o;
  logic              busy_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, rdata_o, err_o, busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, rdata_o, err_o, busy_o
  );

endinterface

// File: rtl/dmem_responder_ram_core.sv
// Word-addressed data RAM: synchronous write, asynchronous read, contents never cleared.
module dmem_ram_core
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Commit a store on the clock edge it is enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack handshake with programmable wait states, error reporting and
// a busy stall source for the hazard unit. All bus outputs except busy_o are registered.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);

  localparam int unsigned    AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned    CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              resp_entry;
  logic              eff_we;
  logic [WORD_W-1:0] eff_addr;
  logic [WORD_W-1:0] eff_wdata;
  logic              eff_err;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  // With no wait states the RESP-entry edge is the acceptance edge itself, so the live bus
  // fields are used there; otherwise the copies captured at acceptance are used.
  always_comb begin
    if (state_q == IDLE) begin
      eff_we    = bus.we_i;
      eff_addr  = bus.addr_i;
      eff_wdata = bus.wdata_i;
    end else begin
      eff_we    = we_q;
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
    end
    eff_err = addr_err(eff_addr, DEPTH);
  end

  // Sequencing: capture the request in IDLE, count wait states, respond for one cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_entry = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          we_d    = bus.we_i;
          addr_d  = bus.addr_i;
          wdata_d = bus.wdata_i;
          cnt_d   = CNT_LOAD;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            resp_entry = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d    = RESP;
          resp_entry = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response generation on the RESP-entry edge; faulting accesses never touch the RAM.
  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    ram_we  = 1'b0;
    if (resp_entry) begin
      ack_d = 1'b1;
      err_d = eff_err;
      if (eff_err) begin
        rdata_d = '0;
      end else if (eff_we) begin
        ram_we = !reset;
      end else begin
        rdata_d = ram_rdata;
      end
    end
  end

  // State, capture and output registers; reset drops any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  dmem_ram_core #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (eff_addr[AW+1:2]),
    .wdata_i (eff_wdata),
    .rdata_o (ram_rdata)
  );

  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.rdata_o = rdata_q;
  assign bus.busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 wait states and 0 wait states) checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned W_A   = 2;
  localparam int unsigned W_B   = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ack   [2];
  logic        err   [2];
  logic        busy  [2];
  logic [31:0] rdata [2];

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  assign bus_a.req_i = req[0];  assign bus_a.we_i = we[0];
  assign bus_a.addr_i = addr[0]; assign bus_a.wdata_i = wdata[0];
  assign bus_b.req_i = req[1];  assign bus_b.we_i = we[1];
  assign bus_b.addr_i = addr[1]; assign bus_b.wdata_i = wdata[1];
  assign ack[0] = bus_a.ack_o; assign err[0] = bus_a.err_o;
  assign busy[0] = bus_a.busy_o; assign rdata[0] = bus_a.rdata_o;
  assign ack[1] = bus_b.ack_o; assign err[1] = bus_b.err_o;
  assign busy[1] = bus_b.busy_o; assign rdata[1] = bus_b.rdata_o;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W_A)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W_B)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned ecount   = 0;
  int unsigned dut_acks [2] = '{0, 0};
  bit          running  = 1'b1;

  function automatic void chk(input string name, input int ch, input logic [31:0] got,
                              input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d: got %h, expected %h (t=%0t)", name, ch, got, exp, $time);
    end
  endfunction

  function automatic int unsigned wc(input int ch);
    return (ch == 0) ? W_A : W_B;
  endfunction

  // ---------------- transaction-level model ----------------
  // A request sampled at edge e is taken when the responder is free (e >= free_edge); its
  // response appears after edge e+W and the responder can take the next one at edge e+W+2.
  logic [31:0] mmem      [2][DEPTH];
  int unsigned free_edge [2] = '{0, 0};
  bit          pend      [2] = '{0, 0};
  int unsigned pend_edge [2];
  logic        pwe       [2];
  logic [31:0] paddr     [2];
  logic [31:0] pwdata    [2];
  logic        exp_ack   [2] = '{0, 0};
  logic        exp_err   [2] = '{0, 0};
  logic        exp_busy  [2] = '{0, 0};
  logic [31:0] exp_rdata [2] = '{0, 0};

  initial begin
    logic       bad;
    logic [5:0] idx;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int ch = 0; ch < 2; ch++) begin
          pend[ch] = 1'b0; free_edge[ch] = 0;
          exp_ack[ch] = 1'b0; exp_err[ch] = 1'b0; exp_busy[ch] = 1'b0; exp_rdata[ch] = '0;
        end
      end else begin
        ecount++;
        for (int ch = 0; ch < 2; ch++) begin
          exp_ack[ch] = 1'b0;
          exp_err[ch] = 1'b0;
          if (req[ch] && ecount >= free_edge[ch]) begin
            pend[ch] = 1'b1; pend_edge[ch] = ecount + wc(ch);
            pwe[ch] = we[ch]; paddr[ch] = addr[ch]; pwdata[ch] = wdata[ch];
            free_edge[ch] = ecount + wc(ch) + 2;
          end
          if (pend[ch] && ecount == pend_edge[ch]) begin
            pend[ch] = 1'b0;
            bad = (paddr[ch] % 4 != 0) || (paddr[ch] / 4 >= DEPTH);
            idx = paddr[ch][7:2];
            exp_ack[ch] = 1'b1;
            exp_err[ch] = bad;
            if (bad) exp_rdata[ch] = '0;
            else if (pwe[ch]) mmem[ch][idx] = pwdata[ch];
            else exp_rdata[ch] = mmem[ch][idx];
          end
          exp_busy[ch] = (ecount + 1 < free_edge[ch]);
        end
      end
    end
  end

  // Every-cycle comparison of all outputs, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (running) begin
        for (int ch = 0; ch < 2; ch++) begin
          if (ack[ch] === 1'b1) dut_acks[ch]++;
          chk("ack", ch, 32'(ack[ch]), 32'(exp_ack[ch]));
          chk("err", ch, 32'(err[ch]), 32'(exp_err[ch]));
          chk("busy", ch, 32'(busy[ch]), 32'(exp_busy[ch]));
          chk("rdata", ch, rdata[ch], exp_rdata[ch]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ack(input int ch, output bit got, output int unsigned e);
    got = 1'b0; e = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack[ch] === 1'b1) begin got = 1'b1; e = ecount; end
    end
    chk("ack_seen", ch, 32'(got), 32'd1);
  endtask

  task automatic xfer(input int ch, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int unsigned lat, output logic [31:0] rd, output logic er);
    int unsigned start, e;
    bit got;
    @(posedge clk); #1;
    req[ch] = 1'b1; we[ch] = w; addr[ch] = a; wdata[ch] = d;
    start = ecount + 1;
    wait_ack(ch, got, e);
    lat = e - start; rd = rdata[ch]; er = err[ch];
    @(posedge clk); #1;
    req[ch] = 1'b0;
  endtask

  task automatic fill(input int ch);
    int unsigned lat; logic [31:0] rd; logic er;
    for (int unsigned i = 0; i < DEPTH; i++) xfer(ch, 1'b1, i * 4, $urandom, lat, rd, er);
  endtask

  task automatic rand_traffic(input int ch, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req[ch]   = ($urandom_range(0, 3) != 0);
      we[ch]    = $urandom_range(0, 1) != 0;
      wdata[ch] = $urandom;
      case ($urandom_range(0, 9))
        0:       addr[ch] = $urandom | 32'h0000_0100;
        1:       addr[ch] = ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
        2:       addr[ch] = DEPTH * 4;
        default: addr[ch] = $urandom_range(0, DEPTH - 1) * 4;
      endcase
    end
    @(posedge clk); #1;
    req[ch] = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog ch0: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int unsigned lat, e1, e2, acks0;
    logic [31:0] rd;
    logic er;
    bit got;
    for (int ch = 0; ch < 2; ch++) begin
      req[ch] = 1'b0; we[ch] = 1'b0; addr[ch] = '0; wdata[ch] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    chk("reset_ack", 0, 32'(ack[0]), 32'd0);
    chk("reset_busy", 1, 32'(busy[1]), 32'd0);
    chk("reset_rdata", 0, rdata[0], 32'd0);

    fork
      fill(0);
      fill(1);
    join

    // write then read back, fixed latency
    xfer(0, 1'b1, 32'h54, 32'h0000_0007, lat, rd, er);
    chk("t2_wr_lat", 0, lat, 32'd2);
    chk("t2_wr_err", 0, 32'(er), 32'd0);
    xfer(0, 1'b0, 32'h54, 32'hFFFF_FFFF, lat, rd, er);
    chk("t2_rd_data", 0, rd, 32'h0000_0007);
    chk("t2_rd_lat", 0, lat, 32'd2);

    // zero wait states
    xfer(1, 1'b1, 32'h0, 32'hA5A5_0001, lat, rd, er);
    xfer(1, 1'b0, 32'h0, 32'h0, lat, rd, er);
    chk("t3_lat", 1, lat, 32'd0);
    chk("t3_data", 1, rd, 32'hA5A5_0001);

    // faulting accesses
    xfer(0, 1'b1, 32'h55, 32'h1234_5678, lat, rd, er);
    chk("t4_mis_err", 0, 32'(er), 32'd1);
    xfer(0, 1'b0, 32'h54, 32'h0, lat, rd, er);
    chk("t4_mem_kept", 0, rd, 32'h0000_0007);
    xfer(0, 1'b0, 32'h100, 32'h0, lat, rd, er);
    chk("t4_oor_err", 0, 32'(er), 32'd1);
    chk("t4_oor_data", 0, rd, 32'd0);

    // back-to-back with req held high
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0; wdata[0] = 32'd1;
    wait_ack(0, got, e1);
    @(posedge clk); #1;
    addr[0] = 32'h4; wdata[0] = 32'd2;
    wait_ack(0, got, e2);
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk("t5_gap", 0, e2 - e1, 32'd4);
    xfer(0, 1'b0, 32'h0, 32'h0, lat, rd, er);
    chk("t5_rd0", 0, rd, 32'd1);
    xfer(0, 1'b0, 32'h4, 32'h0, lat, rd, er);
    chk("t5_rd4", 0, rd, 32'd2);

    // req dropped in the first wait cycle
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    @(posedge clk); #1;
    req[0] = 1'b0; addr[0] = 32'h55;
    acks0 = dut_acks[0];
    repeat (8) @(negedge clk);
    chk("t6_one_ack", 0, dut_acks[0] - acks0, 32'd1);

    // reset while a write is waiting
    xfer(0, 1'b1, 32'h8, 32'h1111_2222, lat, rd, er);
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req[0] = 1'b0;
    reset = 1'b1;
    #1;
    chk("t1_ack", 0, 32'(ack[0]), 32'd0);
    chk("t1_busy", 0, 32'(busy[0]), 32'd0);
    chk("t1_rdata", 0, rdata[0], 32'd0);
    acks0 = dut_acks[0];
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("t1_no_ack", 0, dut_acks[0] - acks0, 32'd0);
    xfer(0, 1'b0, 32'h8, 32'h0, lat, rd, er);
    chk("t1_prior", 0, rd, 32'h1111_2222);

    // randomized traffic on both instances
    fork
      rand_traffic(0, 400);
      rand_traffic(1, 400);
    join

    @(posedge clk);
    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
